// File: rtl/mb_audio_pkg.sv
// mb_audio_pkg: shared widths, FSM states and stereo sample type for the Mockingboard audio path
package mb_audio_pkg;
    localparam int IN_W = 10;
    localparam int PCM_W = 16;
    typedef enum logic [2:0] {IDLE, CAPTURE, DC_L, DC_R, VOL_L, VOL_R, EMIT} state_t;
    typedef struct packed {
        logic [PCM_W-1:0] l;
        logic [PCM_W-1:0] r;
    } stereo_t;
    function automatic int sum_w(input int avg_log2);
        return IN_W + avg_log2;
    endfunction
endpackage

// File: rtl/mb_sample_fifo.sv
// mb_sample_fifo: 2-entry valid/ready sample buffer that drops pushes when full and flags a sticky overrun
module mb_sample_fifo #(
    parameter int W = 32
) (
    input  logic         clk_logic,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         overrun_o
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_q, rd_d, ovr_q, ovr_d, pop, wr_en;
    logic [1:0]   cnt_q, cnt_d;
    assign valid_o   = cnt_q != 2'd0;
    assign data_o    = mem_q[rd_q];
    assign overrun_o = ovr_q;
    always_comb begin
        pop   = valid_o && ready_i;
        wr_en = push_i && (!cnt_q[1] || pop);
        mem_d = mem_q;
        if (wr_en) mem_d[rd_q ^ cnt_q[0]] = data_i;
        rd_d  = rd_q ^ pop;
        cnt_d = cnt_q + {1'b0, wr_en} - {1'b0, pop};
        ovr_d = ovr_q || (push_i && !wr_en);
    end
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
            ovr_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end
endmodule

// File: rtl/mb_audio_resampler.sv
// mb_audio_resampler: averages PSG sums, resamples to SAMPLE_HZ, removes DC, applies volume and buffers stereo PCM
module mb_audio_resampler
    import mb_audio_pkg::*;
#(
    parameter int CLK_HZ    = 54_000_000,
    parameter int SAMPLE_HZ = 48_000,
    parameter int AVG_LOG2  = 4,
    parameter int DC_SHIFT  = 10
) (
    input  logic        clk_logic,
    input  logic        reset,
    input  logic        ce_i,
    input  logic        enable_i,
    input  logic [9:0]  audio_l_i,
    input  logic [9:0]  audio_r_i,
    input  logic [3:0]  volume_i,
    output logic [15:0] sample_l_o,
    output logic [15:0] sample_r_o,
    output logic        sample_valid_o,
    input  logic        sample_ready_i,
    output logic        overrun_o
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = sum_w(AVG_LOG2);
    localparam int DW    = IN_W + DC_SHIFT;

    if (CLK_HZ < 8 * SAMPLE_HZ) begin : g_rate_check
        $error("CLK_HZ must be at least 8*SAMPLE_HZ");
    end

    state_t                 state_q, state_d;
    logic [31:0]            phase_q, phase_d;
    logic [32:0]            phase_sum;
    logic                   tick;
    logic [AVG_LOG2-1:0]    wp_q, wp_d;
    logic [IN_W-1:0]        win_l_q [DEPTH];
    logic [IN_W-1:0]        win_l_d [DEPTH];
    logic [IN_W-1:0]        win_r_q [DEPTH];
    logic [IN_W-1:0]        win_r_d [DEPTH];
    logic [IN_W-1:0]        new_l, new_r;
    logic [SW-1:0]          sum_l_q, sum_l_d, sum_r_q, sum_r_d;
    logic [IN_W-1:0]        avg_l_q, avg_l_d, avg_r_q, avg_r_d, avg_sel, leak;
    logic [DW-1:0]          dc_l_q, dc_l_d, dc_r_q, dc_r_d, dc_sel, dc_new;
    logic signed [IN_W:0]   y_l_q, y_l_d, y_r_q, y_r_d, y_new, y_sel;
    logic signed [PCM_W-1:0] prod;
    logic [PCM_W-1:0]       pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
    stereo_t                fifo_in, fifo_out;

    // The phase wraps by CLK_HZ, so the long-run tick rate is exactly SAMPLE_HZ.
    always_comb begin
        phase_sum = {1'b0, phase_q} + 33'(SAMPLE_HZ);
        tick      = phase_sum >= 33'(CLK_HZ);
        phase_d   = tick ? 32'(phase_sum - 33'(CLK_HZ)) : phase_sum[31:0];
        state_d   = state_q == IDLE ? (tick ? CAPTURE : IDLE)
                  : state_q == EMIT ? IDLE : state_t'(state_q + 3'd1);
    end

    always_comb begin
        new_l   = enable_i ? audio_l_i : '0;
        new_r   = enable_i ? audio_r_i : '0;
        win_l_d = win_l_q;
        win_r_d = win_r_q;
        sum_l_d = sum_l_q;
        sum_r_d = sum_r_q;
        wp_d    = wp_q;
        if (ce_i) begin
            win_l_d[wp_q] = new_l;
            win_r_d[wp_q] = new_r;
            sum_l_d       = sum_l_q + SW'(new_l) - SW'(win_l_q[wp_q]);
            sum_r_d       = sum_r_q + SW'(new_r) - SW'(win_r_q[wp_q]);
            wp_d          = wp_q + AVG_LOG2'(1);
        end
    end

    // DC and volume stages share one datapath each, steered by the FSM state.
    always_comb begin
        avg_l_d = state_q == CAPTURE ? IN_W'(sum_l_q >> AVG_LOG2) : avg_l_q;
        avg_r_d = state_q == CAPTURE ? IN_W'(sum_r_q >> AVG_LOG2) : avg_r_q;
        dc_sel  = state_q == DC_L ? dc_l_q : dc_r_q;
        avg_sel = state_q == DC_L ? avg_l_q : avg_r_q;
        leak    = IN_W'(dc_sel >> DC_SHIFT);
        y_new   = $signed({1'b0, avg_sel}) - $signed({1'b0, leak});
        dc_new  = dc_sel + DW'(avg_sel) - DW'(leak);
        dc_l_d  = state_q == DC_L ? dc_new : dc_l_q;
        dc_r_d  = state_q == DC_R ? dc_new : dc_r_q;
        y_l_d   = state_q == DC_L ? y_new : y_l_q;
        y_r_d   = state_q == DC_R ? y_new : y_r_q;
        y_sel   = state_q == VOL_L ? y_l_q : y_r_q;
        prod    = PCM_W'(y_sel) * PCM_W'($signed({1'b0, volume_i}));
        pcm_l_d = state_q == VOL_L ? {prod[PCM_W-2:0], 1'b0} : pcm_l_q;
        pcm_r_d = state_q == VOL_R ? {prod[PCM_W-2:0], 1'b0} : pcm_r_q;
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            wp_q    <= '0;
            win_l_q <= '{default: '0};
            win_r_q <= '{default: '0};
            sum_l_q <= '0;
            sum_r_q <= '0;
            avg_l_q <= '0;
            avg_r_q <= '0;
            dc_l_q  <= '0;
            dc_r_q  <= '0;
            y_l_q   <= '0;
            y_r_q   <= '0;
            pcm_l_q <= '0;
            pcm_r_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wp_q    <= wp_d;
            win_l_q <= win_l_d;
            win_r_q <= win_r_d;
            sum_l_q <= sum_l_d;
            sum_r_q <= sum_r_d;
            avg_l_q <= avg_l_d;
            avg_r_q <= avg_r_d;
            dc_l_q  <= dc_l_d;
            dc_r_q  <= dc_r_d;
            y_l_q   <= y_l_d;
            y_r_q   <= y_r_d;
            pcm_l_q <= pcm_l_d;
            pcm_r_q <= pcm_r_d;
        end
    end

    assign fifo_in    = '{l: pcm_l_q, r: pcm_r_q};
    assign sample_l_o = fifo_out.l;
    assign sample_r_o = fifo_out.r;

    mb_sample_fifo #(.W(2 * PCM_W)) u_fifo (
        .clk_logic (clk_logic),
        .reset     (reset),
        .push_i    (state_q == EMIT),
        .data_i    (fifo_in),
        .ready_i   (sample_ready_i),
        .data_o    (fifo_out),
        .valid_o   (sample_valid_o),
        .overrun_o (overrun_o)
    );
endmodule
